// File: rtl/stopwatch_run_control_pkg.sv
// Shared stopwatch constants: run-control state encodings and default timing
// values, also used by the display stage.
package stopwatch_run_control_pkg;

    localparam int unsigned DIV_COUNT_DEF  = 500000;
    localparam int unsigned DEB_CYCLES_DEF = 1000000;
    localparam int unsigned CLR_CYCLES_DEF = 4;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioning: 2-FF synchroniser, stability counter and a one-cycle
// registered pulse on each accepted press (debounced 1->0).
module button_debounce
    import stopwatch_run_control_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ;
    logic             settle;

    // The level flips on the DEB_CYCLES-th consecutive sample that disagrees with it.
    assign differ = (sync2_q != level_q);
    assign settle = differ && (cnt_q == CNT_W'(DEB_CYCLES - 1));

    always_comb begin
        level_d = settle ? sync2_q : level_q;
        press_d = settle && !sync2_q;
        if (!differ || settle) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_run_control.sv
// Run/pause/clear control for the stopwatch ripple counter: drives its clock
// with a prescaled one-cycle tick and its active-low reset, all registered.
module stopwatch_run_control
    import stopwatch_run_control_pkg::*;
#(
    parameter int unsigned DIV_COUNT  = DIV_COUNT_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_start_n,
    input  logic btn_clear_n,
    output logic count_clk,
    output logic count_reset_n,
    output logic running
);

    localparam int unsigned PRE_W = $clog2(DIV_COUNT);
    localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

    logic             start_ev, clear_ev;
    logic [1:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CLR_W-1:0] clr_q, clr_d;
    logic             count_clk_q, count_clk_d;
    logic             count_reset_n_q;
    logic             running_q;
    logic             wrap;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .btn_ni  (btn_start_n),
        .press_o (start_ev)
    );

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .btn_ni  (btn_clear_n),
        .press_o (clear_ev)
    );

    always_comb begin
        state_d = state_q;
        clr_d   = '0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_q == CLR_W'(CLR_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            ST_IDLE:  if (start_ev) state_d = ST_RUN;
            ST_RUN:   if (start_ev) state_d = ST_PAUSE;
            ST_PAUSE: if (start_ev) state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
        // Clear overrides a coincident start and restarts an ongoing clear.
        if (clear_ev) begin
            state_d = ST_CLEAR;
            clr_d   = '0;
        end
    end

    assign wrap = (state_q == ST_RUN) && (pre_q == PRE_W'(DIV_COUNT - 1));

    // A stop or clear landing on the wrap cycle suppresses that tick.
    always_comb begin
        pre_d       = pre_q;
        count_clk_d = wrap && (state_d == ST_RUN);
        if (state_d == ST_CLEAR) begin
            pre_d = '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            pre_d = wrap ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_CLEAR;
            clr_q           <= '0;
            pre_q           <= '0;
            count_clk_q     <= 1'b0;
            count_reset_n_q <= 1'b0;
            running_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_q           <= clr_d;
            pre_q           <= pre_d;
            count_clk_q     <= count_clk_d;
            count_reset_n_q <= (state_q != ST_CLEAR);
            running_q       <= (state_q == ST_RUN);
        end
    end

    assign count_clk     = count_clk_q;
    assign count_reset_n = count_reset_n_q;
    assign running       = running_q;

endmodule

// File: tb/tb_stopwatch_run_control.sv
// Bench for stopwatch_run_control: cycle-level behavioural model feeding an
// expected queue, directed scenarios with literal pins, then random button traffic.
module tb_stopwatch_run_control;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int CLR = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_start_n = 1'b1;
    logic btn_clear_n = 1'b1;
    logic count_clk, count_reset_n, running;

    always #5 clk = ~clk;

    stopwatch_run_control #(
        .DIV_COUNT  (DIV),
        .DEB_CYCLES (DEB),
        .CLR_CYCLES (CLR)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_start_n   (btn_start_n),
        .btn_clear_n   (btn_clear_n),
        .count_clk     (count_clk),
        .count_reset_n (count_reset_n),
        .running       (running)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {S_CLEAR, S_IDLE, S_RUN, S_PAUSE} mstate_e;

    logic [2:0] exp_q[$];          // {count_clk, count_reset_n, running}
    int      m_s1[2], m_s2[2], m_run[2], m_lvl[2];
    bit      m_ev[2];
    mstate_e m_state;
    int      m_left;               // cycles of CLEAR still to go
    int      m_phase;              // cycles of RUN since the last tick

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1; m_s2[b] = 1; m_run[b] = 0; m_lvl[b] = 1; m_ev[b] = 0;
        end
        m_state = S_CLEAR;
        m_left  = CLR;
        m_phase = 0;
        exp_q.delete();
        exp_q.push_back(3'b000);
    endtask

    task automatic model_step();
        bit      ev_start, ev_clear, tick;
        int      raw[2];
        mstate_e nxt;
        ev_start = m_ev[0];
        ev_clear = m_ev[1];
        raw[0] = int'(btn_start_n);
        raw[1] = int'(btn_clear_n);
        for (int b = 0; b < 2; b++) begin
            m_ev[b] = 0;
            if (m_s2[b] == m_lvl[b]) m_run[b] = 0;
            else begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = m_s2[b];
                    m_run[b] = 0;
                    m_ev[b]  = (m_s2[b] == 0);
                end
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
        nxt = m_state;
        if (m_state == S_CLEAR) begin
            m_left--;
            if (m_left == 0) nxt = S_IDLE;
        end else if (ev_start) begin
            nxt = (m_state == S_RUN) ? S_PAUSE : S_RUN;
        end
        if (ev_clear) begin
            nxt = S_CLEAR;
            m_left = CLR;
        end
        tick = (m_state == S_RUN) && (nxt == S_RUN) && (m_phase == DIV - 1);
        if (nxt == S_CLEAR) m_phase = 0;
        else if (m_state == S_RUN && nxt == S_RUN) m_phase = (m_phase + 1) % DIV;
        exp_q.push_back({tick, m_state != S_CLEAR, m_state == S_RUN});
        m_state = nxt;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("model_queue_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("cyc_count_clk", int'(count_clk), int'(e[2]));
                check("cyc_count_reset_n", int'(count_reset_n), int'(e[1]));
                check("cyc_running", int'(running), int'(e[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic release_after(input int which, input int cycles);
        fork
            begin
                repeat (cycles) @(negedge clk);
                if (which != 1) btn_start_n = 1'b1;
                if (which != 0) btn_clear_n = 1'b1;
            end
        join_none
    endtask

    task automatic wait_sig(input string name, input int which, input int max);
        bit ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            ok = (which == 0) ? (count_clk == 1'b1) : (running == 1'b1);
        end
        check(name, int'(ok), 1);
    endtask

    task automatic release_reset_check(input string tag);
        reset_n = 1'b1;
        @(negedge clk);
        check({tag, "_rstn_c1"}, int'(count_reset_n), 0);
        check({tag, "_run_c1"}, int'(running), 0);
        check({tag, "_clk_c1"}, int'(count_clk), 0);
        @(negedge clk);
        check({tag, "_rstn_c2"}, int'(count_reset_n), 0);
        @(negedge clk);
        check({tag, "_rstn_c3"}, int'(count_reset_n), 1);
        check({tag, "_run_c3"}, int'(running), 0);
    endtask

    task automatic press(input int which, input int hold);
        if (which != 1) btn_start_n = 1'b0;
        if (which != 0) btn_clear_n = 1'b0;
        repeat (hold) @(negedge clk);
        btn_start_n = 1'b1;
        btn_clear_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        int r;

        // Reset values and release sequence
        repeat (3) @(negedge clk);
        check("rst_count_clk", int'(count_clk), 0);
        check("rst_count_reset_n", int'(count_reset_n), 0);
        check("rst_running", int'(running), 0);
        release_reset_check("rel1");
        repeat (5) @(negedge clk);

        // Start from IDLE: latency through sync + debounce + FSM + output reg
        btn_start_n = 1'b0;
        release_after(0, 10);
        repeat (6) @(negedge clk);
        check("start_run_not_yet", int'(running), 0);
        @(negedge clk);
        check("start_run_high", int'(running), 1);
        pulses = 0;
        repeat (48) begin
            @(negedge clk);
            pulses += int'(count_clk);
        end
        check("pulses_in_48", pulses, 12);

        // Pause with prescaler at 2, then resume: first tick 2 cycles later
        wait_sig("wait_tick_t3", 0, 10);
        @(negedge clk);
        btn_start_n = 1'b0;
        release_after(0, 8);
        repeat (8) @(negedge clk);
        check("pause_running", int'(running), 0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            pulses += int'(count_clk);
        end
        check("pause_no_pulses", pulses, 0);
        btn_start_n = 1'b0;
        release_after(0, 8);
        wait_sig("wait_resume", 1, 20);
        check("resume_clk_first", int'(count_clk), 0);
        @(negedge clk);
        check("resume_clk_tick", int'(count_clk), 1);

        // Bouncing start button is rejected
        repeat (12) @(negedge clk);
        check("bounce_pre_run", int'(running), 1);
        for (int i = 0; i < 10; i++) begin
            btn_start_n = (i % 2 == 1);
            repeat (2) @(negedge clk);
        end
        btn_start_n = 1'b1;
        repeat (10) @(negedge clk);
        check("bounce_post_run", int'(running), 1);

        // Start and clear accepted together: clear wins
        btn_start_n = 1'b0;
        btn_clear_n = 1'b0;
        release_after(2, 8);
        repeat (7) @(negedge clk);
        check("both_running", int'(running), 0);
        check("both_rstn_c1", int'(count_reset_n), 0);
        check("both_clk", int'(count_clk), 0);
        @(negedge clk);
        check("both_rstn_c2", int'(count_reset_n), 0);
        @(negedge clk);
        check("both_rstn_c3", int'(count_reset_n), 1);
        check("both_running_idle", int'(running), 0);

        // Async reset in a tick cycle
        repeat (12) @(negedge clk);
        btn_start_n = 1'b0;
        release_after(0, 8);
        wait_sig("wait_tick_t6", 0, 40);
        #2 reset_n = 1'b0;
        #1;
        check("areset_count_clk", int'(count_clk), 0);
        check("areset_count_reset_n", int'(count_reset_n), 0);
        check("areset_running", int'(running), 0);
        repeat (3) @(negedge clk);
        release_reset_check("rel2");

        // Random button traffic against the model
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) press(0, $urandom_range(1, 10));
            else if (r < 8) press(1, $urandom_range(1, 10));
            else if (r == 8) press(2, $urandom_range(1, 10));
            else begin
                r = $urandom_range(2, 12);
                for (int k = 0; k < r; k++) begin
                    btn_start_n = ~btn_start_n;
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                end
                btn_start_n = 1'b1;
            end
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
